hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage ARM-subset core (IF/ID/EXE/MEM/WB).
- Shadows the destination and source tags of in-flight instructions in EXE, MEM and WB.
- Decides when the ID stage stalls, when a bubble enters ID/EXE, and when the front end is flushed on a taken branch.
- Counts stall cycles for performance analysis, and optionally drives the EXE operand forwarding muxes.

Parameters:
- TRACK_WB, 0: 1 = a WB-stage destination match also causes a stall (register file without write-through); 0 = WB ignored for stalls.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  4  Rn field.
- id_src2  in  4  Rm/Rd second source.
- id_use_src1  in  1  src1 is read.
- id_use_src2  in  1  src2 is read.
- id_wb_en  in  1  ID instruction writes the register file.
- id_dest  in  4  ID destination (Rd).
- id_mem_read  in  1  ID instruction is a load.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- mem_ready  in  1  data memory ready; 0 freezes the whole pipeline.
- hazard  out  1  data hazard detected for ID.
- freeze_if_id  out  1  hold PC and the IF/ID register.
- bubble_id_exe  out  1  load a NOP into ID/EXE.
- flush  out  1  clear IF/ID and ID/EXE.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.
- exe_wb_en  out  1  debug: tracked EXE entry valid-write.
- exe_dest  out  4  debug: tracked EXE destination.
- mem_wb_en  out  1  debug: tracked MEM entry valid-write.
- mem_dest  out  4  debug: tracked MEM destination.
- fwd_sel_a  out  2  present only with FORWARDING_EN.
- fwd_sel_b  out  2  present only with FORWARDING_EN.

Behaviour:
Tracked entries
- Three registered entries: EXE, MEM, WB. Each holds {wb_en, dest, mem_read, use_src1, src1, use_src2, src2}.
- Reset clears all fields to 0; stall_cnt=0.
- All outputs are combinational from the entries and the current inputs, so with rst high every output is 0.

Match rule
- match(e, s, u) = id_valid & u & e.wb_en & (e.dest == s).
- Evaluated for src1 and src2 against each entry.

Hazard (no forwarding)
- hazard = match on EXE or MEM, plus WB when TRACK_WB=1, for either source.
- hazard is forced to 0 when branch_taken=1: the ID instruction is squashed.

Controls
- freeze_if_id = hazard | ~mem_ready.
- bubble_id_exe = hazard & mem_ready.
- flush = branch_taken & mem_ready.

Update on each rising edge
- Priority order: mem_ready=0 > flush > hazard > normal.
- mem_ready=0: all entries hold; stall_cnt holds.
- flush: EXE entry becomes invalid (all zero); MEM<=EXE; WB<=MEM.
- hazard: EXE entry becomes invalid (bubble); MEM<=EXE; WB<=MEM; stall_cnt increments, saturating at 2^CNT_W-1.
- normal: EXE<=ID fields gated by id_valid (wb_en=id_wb_en&id_valid, mem_read likewise); MEM<=EXE; WB<=MEM.

Boundaries and timing
- Register 0 is not special; the ARM r0 is general purpose.
- A hazard and mem_ready=0 in the same cycle: freeze only, no count.
- Latency: a dependent instruction stalls 2 cycles behind a producer in EXE (3 if TRACK_WB=1), and 1 cycle behind one in MEM.
- Reset asserted mid-stall: entries clear immediately; hazard drops in the same cycle.

Optional Feature:
Macro: FORWARDING_EN

Defined
- fwd_sel_a and fwd_sel_b exist; they select the EXE operand source for the instruction held in the EXE entry.
- Encoding: 01 = MEM result, when MEM.wb_en & MEM.dest == EXE.src & EXE.use_src; else 10 = WB result on the equivalent WB match; else 00 = register file.
- MEM has priority over WB.
- hazard asserts only on a load-use match: EXE.mem_read & match(EXE, ...). MEM/WB matches never stall.

Undefined
- No fwd ports exist; hazard follows the no-forwarding rule above.

Test Plan:
1. Reset, then all inputs 0 -> all outputs 0, stall_cnt=0; hold rst high mid-stall -> hazard drops in the same cycle.
2. ADD r3 (wb_en,dest=3) followed by SUB reading src1=3, no forwarding -> hazard=1, bubble_id_exe=1 for 2 cycles; stall_cnt=2; SUB then enters EXE.
3. Same pair with branch_taken=1 in the dependent cycle -> hazard=0, flush=1; next cycle EXE entry has wb_en=0.
4. Producer in MEM with mem_ready=0 for 3 cycles -> freeze_if_id=1, bubble_id_exe=0, entries unchanged, stall_cnt unchanged.
5. FORWARDING_EN: LDR r5 then ADD using r5 -> 1 stall cycle; after the bubble, the ADD in EXE gets fwd_sel_a=10. With an ALU producer instead: no stall, fwd_sel_a=01.
6. CNT_W=4, sustain hazard for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadows EXE/MEM/WB destination and source tags and drives ID stall, bubble and flush.
// Define FORWARDING_EN to add the EXE operand forwarding selects; stalls then occur only on load-use.
module hazard_scoreboard #(
   parameter int TRACK_WB = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_use_src1,
   input  logic             id_use_src2,
   input  logic             id_wb_en,
   input  logic [3:0]       id_dest,
   input  logic             id_mem_read,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             hazard,
   output logic             freeze_if_id,
   output logic             bubble_id_exe,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             exe_wb_en,
   output logic [3:0]       exe_dest,
   output logic             mem_wb_en,
   output logic [3:0]       mem_dest
`ifdef FORWARDING_EN
   ,
   output logic [1:0]       fwd_sel_a,
   output logic [1:0]       fwd_sel_b
`endif
);

   typedef struct packed {
      logic       wb_en;
      logic [3:0] dest;
      logic       mem_read;
      logic       use_src1;
      logic [3:0] src1;
      logic       use_src2;
      logic [3:0] src2;
   } entry_t;

   entry_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d, id_e;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic raw_exe, hz_raw, hz;

   function automatic logic tag_match(input logic v, input entry_t e, input logic [3:0] s,
                                      input logic u);
      return v & u & e.wb_en & (e.dest == s);
   endfunction

   assign raw_exe = tag_match(id_valid, exe_q, id_src1, id_use_src1)
                  | tag_match(id_valid, exe_q, id_src2, id_use_src2);

`ifdef FORWARDING_EN
   // With forwarding only a load in EXE cannot supply its result in time.
   assign hz_raw = exe_q.mem_read & raw_exe;

   always_comb begin
      fwd_sel_a = 2'b00;
      fwd_sel_b = 2'b00;
      if (exe_q.use_src1 & mem_q.wb_en & (mem_q.dest == exe_q.src1))
         fwd_sel_a = 2'b01;
      else if (exe_q.use_src1 & wb_q.wb_en & (wb_q.dest == exe_q.src1))
         fwd_sel_a = 2'b10;
      if (exe_q.use_src2 & mem_q.wb_en & (mem_q.dest == exe_q.src2))
         fwd_sel_b = 2'b01;
      else if (exe_q.use_src2 & wb_q.wb_en & (wb_q.dest == exe_q.src2))
         fwd_sel_b = 2'b10;
   end
`else
   logic raw_mem, raw_wb;
   assign raw_mem = tag_match(id_valid, mem_q, id_src1, id_use_src1)
                  | tag_match(id_valid, mem_q, id_src2, id_use_src2);
   assign raw_wb  = tag_match(id_valid, wb_q, id_src1, id_use_src1)
                  | tag_match(id_valid, wb_q, id_src2, id_use_src2);
   assign hz_raw  = raw_exe | raw_mem | (raw_wb & (TRACK_WB != 0));
`endif

   // Not every tracked field feeds logic in every build.
   logic unused_fields;
   assign unused_fields = ^{exe_q, mem_q, wb_q};

   assign hz            = hz_raw & ~branch_taken & ~rst;
   assign hazard        = hz;
   assign freeze_if_id  = (hz | ~mem_ready) & ~rst;
   assign bubble_id_exe = hz & mem_ready;
   assign flush         = branch_taken & mem_ready & ~rst;
   assign stall_cnt     = cnt_q;
   assign exe_wb_en     = exe_q.wb_en;
   assign exe_dest      = exe_q.dest;
   assign mem_wb_en     = mem_q.wb_en;
   assign mem_dest      = mem_q.dest;

   always_comb begin
      id_e.wb_en    = id_wb_en & id_valid;
      id_e.dest     = id_dest;
      id_e.mem_read = id_mem_read & id_valid;
      id_e.use_src1 = id_use_src1 & id_valid;
      id_e.src1     = id_src1;
      id_e.use_src2 = id_use_src2 & id_valid;
      id_e.src2     = id_src2;
      exe_d = exe_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      if (mem_ready) begin
         mem_d = exe_q;
         wb_d  = mem_q;
         if (branch_taken) begin
            exe_d = '0;
         end else if (hz) begin
            exe_d = '0;
            if (cnt_q != {CNT_W{1'b1}})
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            exe_d = id_e;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_q <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         exe_q <= exe_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default instance plus a TRACK_WB=1, CNT_W=4 instance on shared inputs.
module tb_hazard_scoreboard;

   logic clk, rst;
   logic id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_read, branch_taken, mem_ready;
   logic [3:0] id_src1, id_src2, id_dest;

   logic hz0, frz0, bub0, fl0, ew0, mw0;
   logic [15:0] cnt0;
   logic [3:0] ed0, md0;
   logic hz1, frz1, bub1, fl1, ew1, mw1;
   logic [3:0] cnt1;
   logic [3:0] ed1, md1;
`ifdef FORWARDING_EN
   logic [1:0] fa0, fb0, fa1, fb1;
`endif

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic v; logic [3:0] s1; logic u1; logic [3:0] s2; logic u2;
      logic wb; logic [3:0] d; logic mr; logic br; logic rdy;
   } stim_t;
   typedef struct packed { logic hz0, hz1, frz, bub, fl; } exp_t;
   exp_t q[$];

   hazard_scoreboard dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
      .id_dest(id_dest), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .hazard(hz0), .freeze_if_id(frz0), .bubble_id_exe(bub0),
      .flush(fl0), .stall_cnt(cnt0), .exe_wb_en(ew0), .exe_dest(ed0), .mem_wb_en(mw0),
      .mem_dest(md0)
`ifdef FORWARDING_EN
      , .fwd_sel_a(fa0), .fwd_sel_b(fb0)
`endif
   );

   hazard_scoreboard #(.TRACK_WB(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
      .id_dest(id_dest), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .hazard(hz1), .freeze_if_id(frz1), .bubble_id_exe(bub1),
      .flush(fl1), .stall_cnt(cnt1), .exe_wb_en(ew1), .exe_dest(ed1), .mem_wb_en(mw1),
      .mem_dest(md1)
`ifdef FORWARDING_EN
      , .fwd_sel_a(fa1), .fwd_sel_b(fb1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1);
   end

   function automatic stim_t mk(input logic v, input logic [3:0] s1, input logic u1,
                                input logic [3:0] s2, input logic u2, input logic wb,
                                input logic [3:0] d, input logic mr, input logic br,
                                input logic rdy);
      stim_t s;
      s.v = v; s.s1 = s1; s.u1 = u1; s.s2 = s2; s.u2 = u2;
      s.wb = wb; s.d = d; s.mr = mr; s.br = br; s.rdy = rdy;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      id_valid = s.v; id_src1 = s.s1; id_use_src1 = s.u1; id_src2 = s.s2;
      id_use_src2 = s.u2; id_wb_en = s.wb; id_dest = s.d; id_mem_read = s.mr;
      branch_taken = s.br; mem_ready = s.rdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [37:0] got;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      #2;
      got = {hz0, frz0, bub0, fl0, cnt0, ew0, ed0, mw0, md0, hz1, frz1, bub1, fl1, cnt1};
      n_chk++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want all zero", got);
      end
      apply(mk(1, 3, 1, 3, 1, 1, 3, 1, 1, 0));
      #1;
      got = {hz0, frz0, bub0, fl0, cnt0, ew0, ed0, mw0, md0, hz1, frz1, bub1, fl1, cnt1};
      n_chk++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL reset_active_inputs: got %b want all zero", got);
      end
   endtask

   task automatic test_raw();
      stim_t st[6];
      exp_t ex[6];
      exp_t e;
      do_reset();
      st[0] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
      for (int i = 1; i < 5; i++) st[i] = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 1);
      st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      ex[0] = 5'b00000; ex[1] = 5'b11110; ex[2] = 5'b11110;
      ex[3] = 5'b01000; ex[4] = 5'b00000; ex[5] = 5'b00000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         apply(st[i]);
         q.push_back(ex[i]);
         #1;
         e = q.pop_front();
         n_chk++;
         if ({hz0, hz1, frz0, bub0, fl0} !== e) begin
            n_fail++;
            $display("FAIL raw_ctrl cyc %0d: got %b want %b", i, {hz0, hz1, frz0, bub0, fl0}, e);
         end
         if (i == 1) begin
            n_chk++;
            if ({ew0, ed0} !== 5'b1_0011) begin
               n_fail++;
               $display("FAIL raw_exe_producer: got %b want 10011", {ew0, ed0});
            end
         end
         if (i == 4) begin
            n_chk++;
            if ({cnt0, ew0, ed0, cnt1, ew1} !== {16'd2, 1'b1, 4'd4, 4'd3, 1'b0}) begin
               n_fail++;
               $display("FAIL raw_after_stall: got cnt0=%0d exe0=%b/%0d cnt1=%0d exe1=%b want 2 1/4 3 0",
                        cnt0, ew0, ed0, cnt1, ew1);
            end
         end
         if (i == 5) begin
            n_chk++;
            if ({ew1, ed1} !== 5'b1_0100) begin
               n_fail++;
               $display("FAIL raw_trackwb_enter: got %b want 10100", {ew1, ed1});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      apply(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 1));
      @(negedge clk);
      apply(mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 1));
      #1;
      n_chk++;
      if ({hz0, hz1} !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_stall_pre: got %b want 11", {hz0, hz1});
      end
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if ({hz0, hz1, bub0, frz0, ew0, ew1} !== 6'b0) begin
         n_fail++;
         $display("FAIL mid_stall_reset: got %b want 000000", {hz0, hz1, bub0, frz0, ew0, ew1});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_branch();
      stim_t st[3];
      exp_t ex[3];
      exp_t e;
      do_reset();
      st[0] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
      st[1] = mk(1, 3, 1, 0, 0, 1, 4, 0, 1, 1);
      st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      ex[0] = 5'b00000; ex[1] = 5'b00001; ex[2] = 5'b00000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         apply(st[i]);
         q.push_back(ex[i]);
         #1;
         e = q.pop_front();
         n_chk++;
         if ({hz0, hz1, frz0, bub0, fl0} !== e) begin
            n_fail++;
            $display("FAIL branch_ctrl cyc %0d: got %b want %b", i, {hz0, hz1, frz0, bub0, fl0}, e);
         end
      end
      n_chk++;
      if ({ew0, mw0, md0, cnt0, ew1} !== {1'b0, 1'b1, 4'd3, 16'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL branch_flushed: got exe=%b mem=%b/%0d cnt=%0d exe1=%b want 0 1/3 0 0",
                  ew0, mw0, md0, cnt0, ew1);
      end
   endtask

   task automatic test_mem_freeze();
      stim_t st[7];
      exp_t ex[7];
      exp_t e;
      do_reset();
      st[0] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
      st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      st[2] = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 0);
      st[3] = mk(1, 3, 1, 0, 0, 1, 4, 0, 1, 0);
      st[4] = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 0);
      st[5] = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 1);
      st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      ex[0] = 5'b00000; ex[1] = 5'b00000; ex[2] = 5'b11100; ex[3] = 5'b00100;
      ex[4] = 5'b11100; ex[5] = 5'b11110; ex[6] = 5'b00000;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         apply(st[i]);
         q.push_back(ex[i]);
         #1;
         e = q.pop_front();
         n_chk++;
         if ({hz0, hz1, frz0, bub0, fl0} !== e) begin
            n_fail++;
            $display("FAIL freeze_ctrl cyc %0d: got %b want %b", i, {hz0, hz1, frz0, bub0, fl0}, e);
         end
         if (i >= 2 && i <= 5) begin
            n_chk++;
            if ({mw0, md0, ew0, cnt0, mw1, md1, cnt1} !== {1'b1, 4'd3, 1'b0, 16'd0, 1'b1, 4'd3, 4'd0}) begin
               n_fail++;
               $display("FAIL freeze_hold cyc %0d: got mem=%b/%0d exe=%b cnt0=%0d cnt1=%0d want 1/3 0 0 0",
                        i, mw0, md0, ew0, cnt0, cnt1);
            end
         end
      end
      n_chk++;
      if ({cnt0, cnt1} !== {16'd1, 4'd1}) begin
         n_fail++;
         $display("FAIL freeze_release_cnt: got %0d/%0d want 1/1", cnt0, cnt1);
      end
   endtask

   task automatic test_r0();
      stim_t st[5];
      exp_t ex[5];
      exp_t e;
      do_reset();
      st[0] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      st[1] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 1);
      st[2] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      st[3] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      ex[0] = 5'b00000; ex[1] = 5'b00000; ex[2] = 5'b11110; ex[3] = 5'b00000; ex[4] = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         apply(st[i]);
         q.push_back(ex[i]);
         #1;
         e = q.pop_front();
         n_chk++;
         if ({hz0, hz1, frz0, bub0, fl0} !== e) begin
            n_fail++;
            $display("FAIL r0_ctrl cyc %0d: got %b want %b", i, {hz0, hz1, frz0, bub0, fl0}, e);
         end
      end
   endtask

   task automatic test_saturate();
      exp_t e, x;
      do_reset();
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         apply(mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 1));
         x.hz0 = (k % 3) != 0;
         x.hz1 = (k % 4) != 0;
         x.frz = x.hz0;
         x.bub = x.hz0;
         x.fl  = 1'b0;
         q.push_back(x);
         #1;
         e = q.pop_front();
         n_chk++;
         if ({hz0, hz1, frz0, bub0, fl0} !== e) begin
            n_fail++;
            $display("FAIL chain_ctrl cyc %0d: got %b want %b", k, {hz0, hz1, frz0, bub0, fl0}, e);
         end
      end
      @(negedge clk);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      #1;
      n_chk++;
      if ({cnt0, cnt1} !== {16'd20, 4'd15}) begin
         n_fail++;
         $display("FAIL stall_cnt_sat: got %0d/%0d want 20/15", cnt0, cnt1);
      end
   endtask

`ifdef FORWARDING_EN
   task automatic test_forwarding();
      stim_t st[7];
      exp_t ex[7];
      exp_t e;
      do_reset();
      st[0] = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 1);
      st[1] = mk(1, 5, 1, 0, 0, 1, 6, 0, 0, 1);
      st[2] = mk(1, 5, 1, 0, 0, 1, 6, 0, 0, 1);
      st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      st[4] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 1);
      st[5] = mk(1, 0, 0, 7, 1, 1, 8, 0, 0, 1);
      st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      ex[0] = 5'b00000; ex[1] = 5'b11110; ex[2] = 5'b00000; ex[3] = 5'b00000;
      ex[4] = 5'b00000; ex[5] = 5'b00000; ex[6] = 5'b00000;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         apply(st[i]);
         q.push_back(ex[i]);
         #1;
         e = q.pop_front();
         n_chk++;
         if ({hz0, hz1, frz0, bub0, fl0} !== e) begin
            n_fail++;
            $display("FAIL fwd_ctrl cyc %0d: got %b want %b", i, {hz0, hz1, frz0, bub0, fl0}, e);
         end
         if (i == 3) begin
            n_chk++;
            if ({fa0, fb0, fa1, fb1, cnt0} !== {2'b10, 2'b00, 2'b10, 2'b00, 16'd1}) begin
               n_fail++;
               $display("FAIL fwd_load_wb: got a=%b b=%b cnt=%0d want 10 00 1", fa0, fb0, cnt0);
            end
         end
         if (i == 6) begin
            n_chk++;
            if ({fa0, fb0, fa1, fb1, cnt0} !== {2'b00, 2'b01, 2'b00, 2'b01, 16'd1}) begin
               n_fail++;
               $display("FAIL fwd_alu_mem: got a=%b b=%b cnt=%0d want 00 01 1", fa0, fb0, cnt0);
            end
         end
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      test_reset();
`ifdef FORWARDING_EN
      test_forwarding();
`else
      test_raw();
      test_reset_mid();
      test_branch();
      test_mem_freeze();
      test_r0();
      test_saturate();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
